obi_rr_arbiter: RTL and testbench

Shares one OBI slave port, such as one port of the shared dual-port RAM, between `NUM_REQ` OBI masters, for example the per-core data ports of the GPGPU. Arbitration is round-robin and the address phase passes through combinationally. The winner is locked until the slave grants it. Each granted transaction's requester index goes into an in-order ID FIFO, and responses are steered back to that requester using the FIFO.

---
 rtl/obi_rr_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_obi_rr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_arbiter.sv
// Shares one OBI slave port between NUM_REQ masters with a winner lock and an in-order ID FIFO for response steering.
// Define OBI_ARB_RR_EN for round-robin arbitration; leave it undefined for fixed priority (lowest index wins).
module obi_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0]                 we_i,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]      be_i,
  input  logic [NUM_REQ*ADDR_W-1:0]          addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]          wdata_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [DATA_W-1:0]                  rdata_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [DATA_W/8-1:0]                mem_be_o,
  output logic [ADDR_W-1:0]                  mem_addr_o,
  output logic [DATA_W-1:0]                  mem_wdata_o,
  input  logic                               mem_gnt_i,
  input  logic                               mem_rvalid_i,
  input  logic [DATA_W-1:0]                  mem_rdata_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    outstanding_o,
  output logic                               err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  lock_state_e       r_lock_state;
  lock_state_e       w_lock_state_nxt;
  logic [IDX_W-1:0]  r_lock_idx;
  logic [IDX_W-1:0]  w_lock_idx_nxt;

  logic [IDX_W-1:0]  w_prio;
  logic [IDX_W:0]    w_scan_sum;
  logic [IDX_W-1:0]  w_scan_cand;
  logic              w_scan_found;
  logic [IDX_W-1:0]  w_scan_idx;

  logic              w_lock_hold;
  logic              w_win_valid;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_mem_req;
  logic              w_handshake;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  logic [IDX_W-1:0]  r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic [IDX_W-1:0]  w_head;

`ifdef OBI_ARB_RR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IDX_W-1:0]  r_prio;
  logic [IDX_W-1:0]  w_prio_nxt;

  // Priority pointer moves just past the master that was granted.
  always_comb begin
    w_prio_nxt = r_prio;
    if (w_handshake) begin
      w_prio_nxt = (w_win_idx == LAST_IDX) ? {IDX_W{1'b0}} : (w_win_idx + IDX_ONE);
    end else begin
      w_prio_nxt = r_prio;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio <= {IDX_W{1'b0}};
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = {IDX_W{1'b0}};
`endif

  // Scan downwards so the last hit is the one closest to w_prio (modulo NUM_REQ).
  always_comb begin
    w_scan_sum   = {(IDX_W + 1){1'b0}};
    w_scan_cand  = {IDX_W{1'b0}};
    w_scan_found = 1'b0;
    w_scan_idx   = {IDX_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_scan_sum   = {1'b0, w_prio} + (IDX_W + 1)'(i);
      w_scan_sum   = (w_scan_sum >= NREQ_EXT) ? (w_scan_sum - NREQ_EXT) : w_scan_sum;
      w_scan_cand  = w_scan_sum[IDX_W-1:0];
      w_scan_idx   = req_i[w_scan_cand] ? w_scan_cand : w_scan_idx;
      w_scan_found = w_scan_found | req_i[w_scan_cand];
    end
  end

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == {CNT_W{1'b0}});
  assign w_lock_hold = (r_lock_state == LOCK_HELD) && req_i[r_lock_idx];
  assign w_win_valid = w_lock_hold | w_scan_found;
  assign w_win_idx   = w_lock_hold ? r_lock_idx : w_scan_idx;
  assign w_mem_req   = rst_ni & w_win_valid & ~w_full;
  assign w_handshake = w_mem_req & mem_gnt_i;
  assign w_pop       = rst_ni & mem_rvalid_i & ~w_empty;
  assign w_head      = r_fifo[r_rptr];

  // Lock next-state: hold an ungranted winner until the slave grants it or it withdraws.
  always_comb begin
    w_lock_state_nxt = LOCK_IDLE;
    w_lock_idx_nxt   = r_lock_idx;
    case (r_lock_state)
      LOCK_IDLE: begin
        if (w_mem_req && !mem_gnt_i) begin
          w_lock_state_nxt = LOCK_HELD;
          w_lock_idx_nxt   = w_win_idx;
        end else begin
          w_lock_state_nxt = LOCK_IDLE;
        end
      end
      LOCK_HELD: begin
        if (w_lock_hold && !w_handshake) begin
          w_lock_state_nxt = LOCK_HELD;
        end else begin
          w_lock_state_nxt = LOCK_IDLE;
        end
      end
      default: begin
        w_lock_state_nxt = LOCK_IDLE;
      end
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_state <= LOCK_IDLE;
      r_lock_idx   <= {IDX_W{1'b0}};
    end else begin
      r_lock_state <= w_lock_state_nxt;
      r_lock_idx   <= w_lock_idx_nxt;
    end
  end

  // ID FIFO: push the granted index, pop on each response; spurious responses latch the error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= {IDX_W{1'b0}};
      end
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_fifo[r_wptr] <= w_win_idx;
        r_wptr         <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_handshake, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (mem_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // Combinational forwarding of the winner's address phase and routing of the response.
  always_comb begin
    mem_req_o   = w_mem_req;
    mem_we_o    = 1'b0;
    mem_be_o    = {BE_W{1'b0}};
    mem_addr_o  = {ADDR_W{1'b0}};
    mem_wdata_o = {DATA_W{1'b0}};
    gnt_o       = {NUM_REQ{1'b0}};
    rvalid_o    = {NUM_REQ{1'b0}};
    rdata_o     = {DATA_W{1'b0}};
    if (rst_ni && w_win_valid) begin
      mem_we_o    = we_i[w_win_idx];
      mem_be_o    = be_i[int'(w_win_idx) * BE_W +: BE_W];
      mem_addr_o  = addr_i[int'(w_win_idx) * ADDR_W +: ADDR_W];
      mem_wdata_o = wdata_i[int'(w_win_idx) * DATA_W +: DATA_W];
    end else begin
      mem_we_o    = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i]    = w_handshake && (w_win_idx == IDX_W'(i));
      rvalid_o[i] = w_pop && (w_head == IDX_W'(i));
    end
    rdata_o = w_pop ? mem_rdata_i : {DATA_W{1'b0}};
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed, table-driven bench for obi_rr_arbiter (NUM_REQ=4, FIFO_DEPTH=4); expectations follow OBI_ARB_RR_EN.
module tb_obi_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

`ifdef OBI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst_ni;
  logic [NR-1:0]     req_i;
  logic [NR-1:0]     we_i;
  logic [NR*BW-1:0]  be_i;
  logic [NR*AW-1:0]  addr_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR-1:0]     gnt_o;
  logic [NR-1:0]     rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [BW-1:0]     mem_be_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DW-1:0]     mem_rdata_i;
  logic [2:0]        outstanding_o;
  logic              err_o;

  int n_checks = 0;
  int n_errors = 0;

  obi_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    int          win;
    logic [3:0]  e_gnt;
    logic        e_mreq;
    logic [3:0]  e_rvalid;
    logic [31:0] e_rdata;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] req, logic gnt, logic rv, logic [31:0] rdata, int win,
                              logic [3:0] e_gnt, logic e_mreq, logic [3:0] e_rvalid,
                              logic [31:0] e_rdata, logic [2:0] e_out, logic e_err);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.win = win;
    v.e_gnt = e_gnt; v.e_mreq = e_mreq; v.e_rvalid = e_rvalid;
    v.e_rdata = e_rdata; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [31:0] m_addr(int w);
    return (w < 0) ? 32'h0 : (32'h0000_1000 + 32'(w * 16));
  endfunction
  function automatic logic [31:0] m_wdata(int w);
    return (w < 0) ? 32'h0 : (32'hD0D0_0000 + 32'(w));
  endfunction
  function automatic logic [3:0] m_be(int w);
    return (w < 0) ? 4'h0 : (4'b0001 << w);
  endfunction
  function automatic logic m_we(int w);
    return (w < 0) ? 1'b0 : ((w % 2) == 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int pw;
    rst_ni = 1'b0; req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int k = 0; k < NR; k++) begin
      addr_i[k*AW +: AW]  = m_addr(k);
      wdata_i[k*DW +: DW] = m_wdata(k);
      be_i[k*BW +: BW]    = m_be(k);
      we_i[k]             = m_we(k);
    end

    // Fairness: all masters requesting, slave always granting, responses one cycle later.
    for (int c = 0; c < 7; c++) begin
      w  = RR ? (c % 4) : 0;
      pw = RR ? ((c + 3) % 4) : 0;
      vecs.push_back(mk(4'hF, 1'b1, c > 0, 32'hCAFE_0000 + 32'(c), w, m_be(w), 1'b1,
                        (c > 0) ? m_be(pw) : 4'h0, (c > 0) ? 32'hCAFE_0000 + 32'(c) : 32'h0,
                        (c > 0) ? 3'd1 : 3'd0, 1'b0));
    end
    pw = RR ? 2 : 0;
    vecs.push_back(mk(4'h0, 1'b0, 1'b1, 32'hCAFE_0007, -1, 4'h0, 1'b0, m_be(pw), 32'hCAFE_0007, 3'd1, 1'b0));
    // Lock: master 2 held while master 0 joins.
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 32'h0, 2, 4'h0,    1'b1, 4'h0, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, 32'h0, 2, 4'h0,    1'b1, 4'h0, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b0, 1'b0, 32'h0, 2, 4'h0,    1'b1, 4'h0, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 32'h0, 2, 4'b0100, 1'b1, 4'h0, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 32'h0, 0, 4'b0001, 1'b1, 4'h0, 32'h0, 3'd1, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 32'hAAAA_0001, -1, 4'h0, 1'b0, 4'b0100, 32'hAAAA_0001, 3'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 32'hAAAA_0002, -1, 4'h0, 1'b0, 4'b0001, 32'hAAAA_0002, 3'd1, 1'b0));
    // Routing 3,1,3 with a push/pop at occupancy 2, then a spurious response.
    vecs.push_back(mk(4'b1000, 1'b1, 1'b0, 32'h0, 3, 4'b1000, 1'b1, 4'h0, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 32'h0, 1, 4'b0010, 1'b1, 4'h0, 32'h0, 3'd1, 1'b0));
    vecs.push_back(mk(4'b1000, 1'b1, 1'b1, 32'hBBBB_000A, 3, 4'b1000, 1'b1, 4'b1000, 32'hBBBB_000A, 3'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 32'hBBBB_000B, -1, 4'h0, 1'b0, 4'b0010, 32'hBBBB_000B, 3'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 32'hBBBB_000C, -1, 4'h0, 1'b0, 4'b1000, 32'hBBBB_000C, 3'd1, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 32'hBBBB_000D, -1, 4'h0, 1'b0, 4'h0, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 32'h0, -1, 4'h0, 1'b0, 4'h0, 32'h0, 3'd0, 1'b1));
    // FIFO full: four grants, then blocked, pop in the same cycle still blocks.
    for (int c = 0; c < 4; c++) begin
      vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 32'h0, 1, 4'b0010, 1'b1, 4'h0, 32'h0, 3'(c), 1'b1));
    end
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 32'h0, 1, 4'h0, 1'b0, 4'h0, 32'h0, 3'd4, 1'b1));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b1, 32'hCCCC_0001, 1, 4'h0, 1'b0, 4'b0010, 32'hCCCC_0001, 3'd4, 1'b1));
    vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 32'h0, 1, 4'b0010, 1'b1, 4'h0, 32'h0, 3'd3, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 32'hCCCC_0002, -1, 4'h0, 1'b0, 4'b0010, 32'hCCCC_0002, 3'd4, 1'b1));

    // Reset state.
    #2;
    chk("rst gnt", 32'(gnt_o), 32'h0);
    chk("rst mem_req", 32'(mem_req_o), 32'h0);
    chk("rst outstanding", 32'(outstanding_o), 32'h0);
    chk("rst err", 32'(err_o), 32'h0);
    #10 rst_ni = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      req_i = vecs[i].req; mem_gnt_i = vecs[i].gnt;
      mem_rvalid_i = vecs[i].rv; mem_rdata_i = vecs[i].rdata;
      #4;
      chk($sformatf("v%0d gnt", i),         32'(gnt_o),         32'(vecs[i].e_gnt));
      chk($sformatf("v%0d mem_req", i),     32'(mem_req_o),     32'(vecs[i].e_mreq));
      chk($sformatf("v%0d mem_addr", i),    mem_addr_o,         m_addr(vecs[i].win));
      chk($sformatf("v%0d mem_wdata", i),   mem_wdata_o,        m_wdata(vecs[i].win));
      chk($sformatf("v%0d mem_be", i),      32'(mem_be_o),      32'(m_be(vecs[i].win)));
      chk($sformatf("v%0d mem_we", i),      32'(mem_we_o),      32'(m_we(vecs[i].win)));
      chk($sformatf("v%0d rvalid", i),      32'(rvalid_o),      32'(vecs[i].e_rvalid));
      chk($sformatf("v%0d rdata", i),       rdata_o,            vecs[i].e_rdata);
      chk($sformatf("v%0d outstanding", i), 32'(outstanding_o), 32'(vecs[i].e_out));
      chk($sformatf("v%0d err", i),         32'(err_o),         32'(vecs[i].e_err));
      step();
    end

    // Async reset mid-burst at occupancy 3: outputs clear without a clock edge.
    req_i = 4'hF; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #2;
    chk("pre-rst outstanding", 32'(outstanding_o), 32'd3);
    chk("pre-rst mem_req", 32'(mem_req_o), 32'h1);
    chk("pre-rst rvalid", 32'(rvalid_o), 32'b0010);
    rst_ni = 1'b0;
    #1;
    chk("arst gnt", 32'(gnt_o), 32'h0);
    chk("arst rvalid", 32'(rvalid_o), 32'h0);
    chk("arst rdata", rdata_o, 32'h0);
    chk("arst mem_req", 32'(mem_req_o), 32'h0);
    chk("arst mem_addr", mem_addr_o, 32'h0);
    chk("arst mem_wdata", mem_wdata_o, 32'h0);
    chk("arst mem_be_we", {27'h0, mem_we_o, mem_be_o}, 32'h0);
    chk("arst outstanding", 32'(outstanding_o), 32'h0);
    chk("arst err", 32'(err_o), 32'h0);
    req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    step();
    #4 rst_ni = 1'b1;
    step();

    // Dropped in-flight response arrives after reset.
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #4;
    chk("post-rst spurious rvalid", 32'(rvalid_o), 32'h0);
    step();
    mem_rvalid_i = 1'b0;
    #4;
    chk("post-rst err", 32'(err_o), 32'h1);
    step();

    // Masters 0 and 1 both requesting after reset.
    req_i = 4'b0011; mem_gnt_i = 1'b1;
    #4;
    chk("prio c0 gnt", 32'(gnt_o), 32'b0001);
    step();
    #4;
    chk("prio c1 gnt", 32'(gnt_o), RR ? 32'b0010 : 32'b0001);
    chk("prio c1 addr", mem_addr_o, RR ? m_addr(1) : m_addr(0));
    step();
    #4;
    chk("prio c2 gnt", 32'(gnt_o), 32'b0001);
    step();
    req_i = '0; mem_gnt_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
